updown_counter: RTL and testbench

Parametrised up/down counter that succeeds the team's fixed 8-bit up counter. It adds a programmable modulo limit, direction control, synchronous load, wrap or saturate mode, a clock-enable prescaler and a terminal-count pulse. It is the general-purpose event/timer counter for the design's control logic, instantiated wherever a plain free-running counter is not enough.

---
 rtl/counter_pkg.sv | 9 +
 rtl/counter_prescaler.sv | 36 +++
 rtl/updown_counter.sv | 96 +++++++++
 tb/tb_updown_counter.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared direction/mode encodings for the counter and future timer blocks.
package counter_pkg;

  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

endpackage

// File: rtl/counter_prescaler.sv
// Clock-enable prescaler: tick fires every div+1 enabled cycles; clear restarts the period.
module counter_prescaler
  import counter_pkg::*;
#(
  parameter int PRESC_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               clear,
  input  logic [PRESC_W-1:0] div,
  output logic               tick
);

  logic [PRESC_W-1:0] pcnt_q;
  logic [PRESC_W-1:0] pcnt_d;

  // A shrunk div leaves pcnt above it; the increment then overflows back to 0.
  assign tick = enable && !clear && (pcnt_q == div);

  always_comb begin
    pcnt_d = pcnt_q;
    if (clear) begin
      pcnt_d = '0;
    end else if (enable) begin
      if (pcnt_q == div) pcnt_d = '0;
      else               pcnt_d = pcnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pcnt_q <= '0;
    else     pcnt_q <= pcnt_d;
  end

endmodule

// File: rtl/updown_counter.sv
// Up/down modulo counter with load, wrap/saturate, prescaler and terminal-count pulse.
// Optional compare output enabled by defining UPDOWN_COUNTER_MATCH_EN.
module updown_counter
  import counter_pkg::*;
#(
  parameter int          WIDTH   = 8,
  parameter int unsigned MAX     = (2 ** WIDTH) - 1,
  parameter int          PRESC_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               dir,
  input  logic               sat,
  input  logic [PRESC_W-1:0] presc_div,
  input  logic               load,
  input  logic [WIDTH-1:0]   load_val,
  input  logic [WIDTH-1:0]   cmp_val,
  output logic [WIDTH-1:0]   out,
  output logic               tc,
  output logic               match
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  logic [WIDTH-1:0] out_q, out_d;
  logic             tc_q, tc_d;
  logic             step;
  logic             at_bound;

  function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
    return (v > MAX_V) ? MAX_V : v;
  endfunction

  // Bounds are checked before the arithmetic so a non-power-of-two MAX wraps correctly.
  function automatic logic [WIDTH-1:0] next_count(input logic [WIDTH-1:0] cur,
                                                  input logic up, input logic mode);
    logic [WIDTH-1:0] nxt;
    if (up == DIR_UP) begin
      if (cur < MAX_V)            nxt = cur + 1'b1;
      else if (mode == MODE_SAT)  nxt = MAX_V;
      else                        nxt = '0;
    end else begin
      if (cur > '0)               nxt = cur - 1'b1;
      else if (mode == MODE_SAT)  nxt = '0;
      else                        nxt = MAX_V;
    end
    return nxt;
  endfunction

  counter_prescaler #(
    .PRESC_W (PRESC_W)
  ) u_presc (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .clear  (load),
    .div    (presc_div),
    .tick   (step)
  );

  assign at_bound = (dir == DIR_UP) ? (out_q == MAX_V) : (out_q == '0);

  always_comb begin
    out_d = out_q;
    tc_d  = 1'b0;
    if (load) begin
      out_d = clamp_load(load_val);
    end else if (step) begin
      out_d = next_count(out_q, dir, sat);
      tc_d  = at_bound;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q <= '0;
      tc_q  <= 1'b0;
    end else begin
      out_q <= out_d;
      tc_q  <= tc_d;
    end
  end

  assign out = out_q;
  assign tc  = tc_q;

`ifdef UPDOWN_COUNTER_MATCH_EN
  assign match = (out_q == cmp_val);
`else
  logic unused_cmp;
  assign unused_cmp = ^cmp_val;
  assign match      = 1'b0;
`endif

endmodule

// File: tb/tb_updown_counter.sv
// Directed bench for updown_counter with WIDTH=8, MAX=9, PRESC_W=4.
module tb_updown_counter;

  localparam int WIDTH   = 8;
  localparam int MAX     = 9;
  localparam int PRESC_W = 4;

  logic               clk;
  logic               rst;
  logic               enable;
  logic               dir;
  logic               sat;
  logic [PRESC_W-1:0] presc_div;
  logic               load;
  logic [WIDTH-1:0]   load_val;
  logic [WIDTH-1:0]   cmp_val;
  logic [WIDTH-1:0]   out;
  logic               tc;
  logic               match;

  int n_cmp;
  int n_err;

  updown_counter #(
    .WIDTH   (WIDTH),
    .MAX     (MAX),
    .PRESC_W (PRESC_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .dir       (dir),
    .sat       (sat),
    .presc_div (presc_div),
    .load      (load),
    .load_val  (load_val),
    .cmp_val   (cmp_val),
    .out       (out),
    .tc        (tc),
    .match     (match)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_match(input int o);
`ifdef UPDOWN_COUNTER_MATCH_EN
    return (o == 3) ? 1 : 0;
`else
    return 0;
`endif
  endfunction

  int exp_dn_out[3] = '{1, 0, 9};
  int exp_dn_tc [3] = '{0, 0, 1};
  int ps_en [14] = '{1,1,1,1,1,1,1,1,1,0,0,1,1,1};
  int ps_out[14] = '{0,0,0,1,1,1,1,2,2,2,2,2,2,3};

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1; enable = 1'b0; dir = 1'b1; sat = 1'b0;
    presc_div = '0; load = 1'b0; load_val = '0; cmp_val = 8'd3;
    step_clk();
    step_clk();
    chk("reset_out", out, 0);
    chk("reset_tc", tc, 0);
    chk("reset_match", match, exp_match(0));
    rst = 1'b0;

    // Wrap counting up through MAX=9
    enable = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      step_clk();
      chk("wrap_up_out", out, i % 10);
      chk("wrap_up_tc", tc, (i == 10) ? 1 : 0);
      chk("wrap_up_match", match, exp_match(i % 10));
    end

    // Count down from 2 through 0 into 9, then flip up
    dir = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step_clk();
      chk("wrap_dn_out", out, exp_dn_out[i]);
      chk("wrap_dn_tc", tc, exp_dn_tc[i]);
    end
    dir = 1'b1;
    step_clk();
    chk("flip_up_out", out, 0);
    chk("flip_up_tc", tc, 1);
    step_clk();
    chk("flip_up2_out", out, 1);
    chk("flip_up2_tc", tc, 0);

    // Saturating up from 1
    sat = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step_clk();
      chk("sat_up_out", out, (1 + k > 9) ? 9 : 1 + k);
      chk("sat_up_tc", tc, (k >= 9) ? 1 : 0);
    end

    // Loads override a concurrent step and clamp above MAX
    load = 1'b1; load_val = 8'd4;
    step_clk();
    chk("load4_out", out, 4);
    chk("load4_tc", tc, 0);
    load_val = 8'd200;
    step_clk();
    chk("load200_out", out, 9);
    chk("load200_tc", tc, 0);
    load_val = 8'd0; dir = 1'b0;
    step_clk();
    chk("load0_out", out, 0);
    load = 1'b0;
    step_clk();
    chk("sat_dn_out", out, 0);
    chk("sat_dn_tc", tc, 1);
    step_clk();
    chk("sat_dn2_out", out, 0);
    chk("sat_dn2_tc", tc, 1);

    // Prescaler /4 with a 2-cycle enable gap
    presc_div = 4'd3; dir = 1'b1; sat = 1'b0;
    load = 1'b1; load_val = 8'd0;
    step_clk();
    chk("ps_load_out", out, 0);
    chk("ps_load_tc", tc, 0);
    load = 1'b0;
    for (int e = 0; e < 14; e++) begin
      enable = ps_en[e][0];
      step_clk();
      chk("presc_out", out, ps_out[e]);
    end
    enable = 1'b1;

    // Asynchronous reset between edges discards prescaler progress
    load = 1'b1; load_val = 8'd5;
    step_clk();
    chk("pre_rst_out", out, 5);
    load = 1'b0;
    step_clk();
    step_clk();
    chk("pre_rst_hold", out, 5);
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_out", out, 0);
    chk("async_rst_tc", tc, 0);
    chk("async_rst_match", match, exp_match(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int e = 1; e <= 4; e++) begin
      step_clk();
      chk("post_rst_out", out, (e == 4) ? 1 : 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
